// File: rtl/img_ram_arbiter.sv
// img_ram_arbiter: frame-phase sequencer and round-robin arbiter for the
// single-port image RAM shared by the host loader (A) and the convolution
// engine (B).
//
// Ports
//   clk, initial_reset_n          clock, async active-low reset
//   load_start, conv_done         frame control pulses
//   a_req/a_we/a_addr/a_wdata     port A request (a_last marks final load word)
//   a_gnt/a_rvalid/a_rdata        port A grant and read return
//   b_*                           port B, same as A without b_last
//   ram_w_en/ram_r_en/ram_address/ram_data_in/ram_done   registered RAM controls
//   ram_data_out                  RAM read data (registered inside the RAM)
//   phase                         IDLE=0 LOAD=1 PROCESS=2 FLUSH=3 DONE=4
//   grant_cnt_a/grant_cnt_b/wait_cnt   statistics
//
// Build option: define ARB_STATS_EN to build the saturating statistics
// counters; otherwise the statistics ports are tied to zero.

module img_ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  initial_reset_n,
    input  logic                  load_start,
    input  logic                  conv_done,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  a_last,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_w_en,
    output logic                  ram_r_en,
    output logic                  ram_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [2:0]            phase,
    output logic [15:0]           grant_cnt_a,
    output logic [15:0]           grant_cnt_b,
    output logic [15:0]           wait_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_LOAD    = 3'd1,
        PH_PROCESS = 3'd2,
        PH_FLUSH   = 3'd3,
        PH_DONE    = 3'd4
    } phase_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    phase_t phase_q;
    phase_t phase_d;
    port_t  last_q;
    logic   a_elig_c;
    logic   b_elig_c;
    logic   rd_port_b_q;   // owner of the read currently in the RAM pipeline

    // Phase-dependent eligibility and round-robin grant
    always_comb begin
        a_elig_c = 1'b0;
        b_elig_c = 1'b0;
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        unique case (phase_q)
            PH_LOAD:    a_elig_c = a_req & a_we;
            PH_PROCESS: begin
                a_elig_c = a_req & ~a_we;
                b_elig_c = b_req;
            end
            PH_DONE:    a_elig_c = a_req & ~a_we;
            default:    ;
        endcase
        a_gnt = a_elig_c & (~b_elig_c | (last_q == PORT_B));
        b_gnt = b_elig_c & (~a_elig_c | (last_q == PORT_A));
    end

    // Phase register
    always_ff @(posedge clk or negedge initial_reset_n) begin
        if (!initial_reset_n) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase next-state; FLUSH waits until the access pipeline has emptied
    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            PH_IDLE, PH_DONE: if (load_start) phase_d = PH_LOAD;
            PH_LOAD:          if (a_gnt && a_last) phase_d = PH_PROCESS;
            PH_PROCESS:       if (conv_done) phase_d = PH_FLUSH;
            PH_FLUSH:         if (!ram_w_en && !ram_r_en) phase_d = PH_DONE;
            default:          phase_d = PH_IDLE;
        endcase
    end

    assign phase = 3'(phase_q);

    // RAM command stage and read-return stage
    always_ff @(posedge clk or negedge initial_reset_n) begin
        if (!initial_reset_n) begin
            ram_w_en    <= 1'b0;
            ram_r_en    <= 1'b0;
            ram_done    <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            last_q      <= PORT_B;
            rd_port_b_q <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
        end else begin
            ram_w_en    <= (a_gnt & a_we) | (b_gnt & b_we);
            ram_r_en    <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
            ram_done    <= (phase_d == PH_DONE);
            rd_port_b_q <= b_gnt;
            a_rvalid    <= ram_r_en & ~rd_port_b_q;
            b_rvalid    <= ram_r_en & rd_port_b_q;
            if (a_gnt) begin
                ram_address <= a_addr;
                ram_data_in <= a_wdata;
                last_q      <= PORT_A;
            end else if (b_gnt) begin
                ram_address <= b_addr;
                ram_data_in <= b_wdata;
                last_q      <= PORT_B;
            end
        end
    end

    // RAM output is already registered; gate it so idle ports read zero
    assign a_rdata = a_rvalid ? ram_data_out : '0;
    assign b_rdata = b_rvalid ? ram_data_out : '0;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_ga_q;
    logic [CNT_W-1:0] cnt_gb_q;
    logic [CNT_W-1:0] cnt_wait_q;
    logic             wait_c;
    logic             clr_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // A waits in any phase it can be served in; B only in PROCESS
    always_comb begin
        wait_c = 1'b0;
        clr_c  = load_start & ((phase_q == PH_IDLE) | (phase_q == PH_DONE));
        if ((phase_q == PH_LOAD) || (phase_q == PH_PROCESS) || (phase_q == PH_DONE)) begin
            wait_c = a_req & ~a_gnt;
        end
        if (phase_q == PH_PROCESS) begin
            wait_c = wait_c | (b_req & ~b_gnt);
        end
    end

    // Saturating statistics, cleared when a new frame load is accepted
    always_ff @(posedge clk or negedge initial_reset_n) begin
        if (!initial_reset_n) begin
            cnt_ga_q   <= '0;
            cnt_gb_q   <= '0;
            cnt_wait_q <= '0;
        end else if (clr_c) begin
            cnt_ga_q   <= '0;
            cnt_gb_q   <= '0;
            cnt_wait_q <= '0;
        end else begin
            if (a_gnt)  cnt_ga_q   <= sat_inc(cnt_ga_q);
            if (b_gnt)  cnt_gb_q   <= sat_inc(cnt_gb_q);
            if (wait_c) cnt_wait_q <= sat_inc(cnt_wait_q);
        end
    end

    assign grant_cnt_a = cnt_ga_q;
    assign grant_cnt_b = cnt_gb_q;
    assign wait_cnt    = cnt_wait_q;
`else
    assign grant_cnt_a = '0;
    assign grant_cnt_b = '0;
    assign wait_cnt    = '0;
`endif

endmodule

// File: tb/tb_img_ram_arbiter.sv
// Scoreboard bench for img_ram_arbiter: stimulus pushes expected RAM
// accesses and read returns (tagged with their due cycle); a monitor pops
// and compares whenever the DUT presents a RAM strobe or an rvalid.

module tb_img_ram_arbiter;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 18;
    localparam logic [2:0] P_IDLE = 3'd0, P_LOAD = 3'd1, P_PROC = 3'd2,
                           P_FLUSH = 3'd3, P_DONE = 3'd4;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_start = 1'b0, conv_done = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, a_last = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_w_en, ram_r_en, ram_done;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_dout = '0;
    logic [2:0]    phase;
    logic [15:0]   grant_cnt_a, grant_cnt_b, wait_cnt;

    img_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .initial_reset_n(rst_n),
        .load_start(load_start), .conv_done(conv_done),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_last(a_last),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_done(ram_done),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_dout),
        .phase(phase), .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b),
        .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read, write on w_en
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] exp_mem [256];
    always @(posedge clk) begin
        if (ram_w_en) ram_mem[ram_address[7:0]] <= ram_data_in;
        if (ram_r_en) ram_dout <= ram_mem[ram_address[7:0]];
    end

    typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    acc_t acc_q[$];
    rd_t  ra_q[$];
    rd_t  rb_q[$];

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] exp_ga = '0, exp_gb = '0, exp_wait = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Monitor: match presented strobes against the scoreboard queues
    initial begin
        forever begin : mon
            acc_t e;
            rd_t  r;
            @(negedge clk);
            while (acc_q.size() > 0 && acc_q[0].due < cyc) begin
                e = acc_q.pop_front();
                chk("ram_access_missing", 32'(e.due), 32'(cyc));
            end
            while (ra_q.size() > 0 && ra_q[0].due < cyc) begin
                r = ra_q.pop_front();
                chk("a_rvalid_missing", 32'(r.due), 32'(cyc));
            end
            while (rb_q.size() > 0 && rb_q[0].due < cyc) begin
                r = rb_q.pop_front();
                chk("b_rvalid_missing", 32'(r.due), 32'(cyc));
            end
            if (ram_w_en || ram_r_en) begin
                chk("ram_w_r_exclusive", 32'(ram_w_en & ram_r_en), 32'd0);
                if (acc_q.size() == 0) begin
                    chk("ram_access_unexpected", 32'd1, 32'd0);
                end else begin
                    e = acc_q.pop_front();
                    chk("ram_access_cycle", 32'(cyc), 32'(e.due));
                    chk("ram_w_en", 32'(ram_w_en), 32'(e.we));
                    chk("ram_address", 32'(ram_address), 32'(e.addr));
                    if (e.we) chk("ram_data_in", 32'(ram_data_in), 32'(e.data));
                end
            end
            if (a_rvalid) begin
                if (ra_q.size() == 0) begin
                    chk("a_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    r = ra_q.pop_front();
                    chk("a_rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("a_rdata", 32'(a_rdata), 32'(r.data));
                end
            end
            if (b_rvalid) begin
                if (rb_q.size() == 0) begin
                    chk("b_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rb_q.pop_front();
                    chk("b_rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("b_rdata", 32'(b_rdata), 32'(r.data));
                end
            end
        end
    end

    task automatic push_grant(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic is_b);
        acc_t e;
        rd_t  r;
        e.due = cyc + 1; e.we = we; e.addr = addr; e.data = data;
        acc_q.push_back(e);
        if (we) begin
            exp_mem[addr[7:0]] = data;
        end else begin
            r.due = cyc + 2; r.data = exp_mem[addr[7:0]];
            if (is_b) rb_q.push_back(r); else ra_q.push_back(r);
        end
    endtask

    // One cycle: check grants/phase/stats, record expected responses, advance
    task automatic step(input string nm, input logic ea, input logic eb, input logic [2:0] eph);
        logic w;
        @(negedge clk);
        chk({nm, "/phase"}, 32'(phase), 32'(eph));
        chk({nm, "/a_gnt"}, 32'(a_gnt), 32'(ea));
        chk({nm, "/b_gnt"}, 32'(b_gnt), 32'(eb));
        chk({nm, "/ram_done"}, 32'(ram_done), 32'(eph == P_DONE));
        chk({nm, "/grant_cnt_a"}, 32'(grant_cnt_a), STATS ? 32'(exp_ga) : 32'd0);
        chk({nm, "/grant_cnt_b"}, 32'(grant_cnt_b), STATS ? 32'(exp_gb) : 32'd0);
        chk({nm, "/wait_cnt"}, 32'(wait_cnt), STATS ? 32'(exp_wait) : 32'd0);
        if (ea) push_grant(a_we, a_addr, a_wdata, 1'b0);
        if (eb) push_grant(b_we, b_addr, b_wdata, 1'b1);
        w = ((eph == P_LOAD || eph == P_PROC || eph == P_DONE) && a_req && !ea) ||
            (eph == P_PROC && b_req && !eb);
        if (load_start && (eph == P_IDLE || eph == P_DONE)) begin
            exp_ga = '0; exp_gb = '0; exp_wait = '0;
        end else begin
            if (ea) exp_ga = sat(exp_ga);
            if (eb) exp_gb = sat(exp_gb);
            if (w)  exp_wait = sat(exp_wait);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "/gnt"}, 32'({a_gnt, b_gnt}), 32'd0);
        chk({nm, "/rvalid"}, 32'({a_rvalid, b_rvalid}), 32'd0);
        chk({nm, "/rdata"}, 32'({a_rdata, b_rdata}), 32'd0);
        chk({nm, "/ram_ctl"}, 32'({ram_w_en, ram_r_en, ram_done}), 32'd0);
        chk({nm, "/ram_address"}, 32'(ram_address), 32'd0);
        chk({nm, "/ram_data_in"}, 32'(ram_data_in), 32'd0);
        chk({nm, "/phase"}, 32'(phase), 32'(P_IDLE));
        chk({nm, "/stats"}, 32'(grant_cnt_a | grant_cnt_b | wait_cnt), 32'd0);
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic last);
        a_req = req; a_we = we; a_addr = addr; a_wdata = data; a_last = last;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        b_req = req; b_we = we; b_addr = addr; b_wdata = data;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            exp_mem[i] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IDLE ignores requests; accepted load_start moves to LOAD
        set_a(1, 0, 18'd0, 8'h00, 0);
        step("idle_req", 0, 0, P_IDLE);
        set_a(0, 0, 18'd0, 8'h00, 0);
        load_start = 1'b1;
        step("load_start", 0, 0, P_IDLE);
        load_start = 1'b0;

        // Load three words; PROCESS follows the a_last grant
        set_a(1, 1, 18'd0, 8'h11, 0); step("load_w0", 1, 0, P_LOAD);
        set_a(1, 1, 18'd1, 8'h22, 0); step("load_w1", 1, 0, P_LOAD);
        set_a(1, 1, 18'd2, 8'h33, 1); step("load_w2", 1, 0, P_LOAD);
        set_a(0, 0, 18'd0, 8'h00, 0);
        load_start = 1'b1;
        step("to_process", 0, 0, P_PROC);
        load_start = 1'b0;

        // Conflict: last grant was A, so B wins first and they alternate
        set_a(1, 0, 18'd1, 8'h00, 0);
        set_b(1, 0, 18'd2, 8'h00);
        step("conf0", 0, 1, P_PROC);
        step("conf1", 1, 0, P_PROC);
        step("conf2", 0, 1, P_PROC);
        step("conf3", 1, 0, P_PROC);
        set_a(0, 0, 18'd0, 8'h00, 0);
        set_b(1, 1, 18'd5, 8'h55);
        step("b_write", 0, 1, P_PROC);
        set_b(0, 0, 18'd0, 8'h00);
        set_a(1, 0, 18'd5, 8'h00, 0);
        step("a_read_b_data", 1, 0, P_PROC);

        // A write stalls in PROCESS while B reads proceed
        set_a(1, 1, 18'd7, 8'h77, 0);
        set_b(1, 0, 18'd0, 8'h00);
        for (int i = 0; i < 3; i++) step("blocked", 0, 1, P_PROC);
        set_b(0, 0, 18'd0, 8'h00);
        step("blocked_alone", 0, 0, P_PROC);

        // Flush: grant issued alongside conv_done, then two FLUSH cycles
        set_a(0, 0, 18'd0, 8'h00, 0);
        set_b(1, 0, 18'd0, 8'h00);
        conv_done = 1'b1;
        step("flush_gnt", 0, 1, P_PROC);
        conv_done = 1'b0;
        set_b(0, 0, 18'd0, 8'h00);
        set_a(1, 0, 18'd1, 8'h00, 0);
        step("flush0", 0, 0, P_FLUSH);
        step("flush1", 0, 0, P_FLUSH);
        step("done_a_rd", 1, 0, P_DONE);
        set_a(1, 1, 18'd9, 8'h99, 0);
        step("done_a_wr", 0, 0, P_DONE);
        set_a(0, 0, 18'd0, 8'h00, 0);
        set_b(1, 0, 18'd1, 8'h00);
        conv_done = 1'b1;
        step("done_b_rd", 0, 0, P_DONE);
        conv_done = 1'b0;
        set_b(0, 0, 18'd0, 8'h00);

        // Reset one cycle after a B read grant drops the pending read
        load_start = 1'b1;
        step("reload", 0, 0, P_DONE);
        load_start = 1'b0;
        set_a(1, 1, 18'd3, 8'h44, 1);
        step("reload_w", 1, 0, P_LOAD);
        set_a(0, 0, 18'd0, 8'h00, 0);
        set_b(1, 0, 18'd3, 8'h00);
        step("rst_rd_gnt", 0, 1, P_PROC);
        set_b(0, 0, 18'd0, 8'h00);
        chk("pre_rst_r_en", 32'(ram_r_en), 32'd1);
        rst_n = 1'b0;
        acc_q.delete(); ra_q.delete(); rb_q.delete();
        exp_ga = '0; exp_gb = '0; exp_wait = '0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_b_rvalid", 32'(b_rvalid), 32'd0);
            chk("post_rst_phase", 32'(phase), 32'(P_IDLE));
            @(posedge clk); #1;
        end

`ifdef ARB_STATS_EN
        // Saturation of grant_cnt_b, then clear on an accepted load_start
        load_start = 1'b1;
        step("sat_ls", 0, 0, P_IDLE);
        load_start = 1'b0;
        set_a(1, 1, 18'd0, 8'h11, 1);
        step("sat_w", 1, 0, P_LOAD);
        set_a(0, 0, 18'd0, 8'h00, 0);
        set_b(1, 0, 18'd0, 8'h00);
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if ((i % 1024) == 0) chk("sat_b_gnt", 32'(b_gnt), 32'd1);
            push_grant(1'b0, 18'd0, 8'h00, 1'b1);
            exp_gb = sat(exp_gb);
            @(posedge clk); #1;
        end
        set_b(0, 0, 18'd0, 8'h00);
        step("sat_hold", 0, 0, P_PROC);
        chk("sat_cnt_b", 32'(grant_cnt_b), 32'hFFFF);
        conv_done = 1'b1;
        step("sat_conv", 0, 0, P_PROC);
        conv_done = 1'b0;
        step("sat_flush", 0, 0, P_FLUSH);
        load_start = 1'b1;
        step("sat_clr", 0, 0, P_DONE);
        load_start = 1'b0;
        step("sat_cleared", 0, 0, P_LOAD);
        chk("sat_cnt_b_clear", 32'(grant_cnt_b), 32'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("drain_acc_q", 32'(acc_q.size()), 32'd0);
        chk("drain_ra_q", 32'(ra_q.size()), 32'd0);
        chk("drain_rb_q", 32'(rb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
